sqrt_arbiter: RTL and testbench

- Shares one combinational square_root datapath (8-bit operand in, 16-bit result out) between two requesters in the baggage-drop design.
- Grants requesters round-robin and drives the shared operand bus.
- Waits a programmable settle time, registers the result, and returns it with a one-cycle acknowledge to the served requester.
- Sits between the two measurement channels and the single square_root instance. The square_root instance lives outside this block and connects through sq_in/sq_out.

---
 rtl/sqrt_arbiter.sv | 108 ++++++++++
 tb/tb_sqrt_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one external square_root datapath between two requesters.
// Drives the operand, waits SETTLE_CYCLES edges, then registers the result and pulses the ack.
module sqrt_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [7:0]  in0,
  input  logic        req1,
  input  logic [7:0]  in1,
  output logic [7:0]  sq_in,
  input  logic [15:0] sq_out,
  output logic [15:0] result,
  output logic        ack0,
  output logic        ack1,
  output logic        busy,
  output logic        grant_id
);

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [7:0]  r_sq_in, w_sq_in_next;
  logic [15:0] r_result, w_result_next;
  logic        r_ack0, w_ack0_next;
  logic        r_ack1, w_ack1_next;
  logic        r_busy, w_busy_next;
  logic        r_grant_id, w_grant_id_next;
  logic        r_last_grant, w_last_grant_next;

  logic w_elig0, w_elig1, w_sel;

  // A channel being acked this cycle is still dropping its req, so it cannot win.
  assign w_elig0 = req0 & ~r_ack0;
  assign w_elig1 = req1 & ~r_ack1;
  assign w_sel   = (w_elig0 & w_elig1) ? ~r_last_grant : w_elig1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_sq_in      <= 8'd0;
      r_result     <= 16'd0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_busy       <= 1'b0;
      r_grant_id   <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_sq_in      <= w_sq_in_next;
      r_result     <= w_result_next;
      r_ack0       <= w_ack0_next;
      r_ack1       <= w_ack1_next;
      r_busy       <= w_busy_next;
      r_grant_id   <= w_grant_id_next;
      r_last_grant <= w_last_grant_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_sq_in_next      = r_sq_in;
    w_result_next     = r_result;
    w_ack0_next       = 1'b0;
    w_ack1_next       = 1'b0;
    w_busy_next       = r_busy;
    w_grant_id_next   = r_grant_id;
    w_last_grant_next = r_last_grant;
    case (r_state)
      IDLE: begin
        if (w_elig0 | w_elig1) begin
          w_state_next      = WAIT;
          w_sq_in_next      = w_sel ? in1 : in0;
          w_grant_id_next   = w_sel;
          w_last_grant_next = w_sel;
          w_cnt_next        = SETTLE;
          w_busy_next       = 1'b1;
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_result_next = sq_out;
          w_ack0_next   = ~r_grant_id;
          w_ack1_next   = r_grant_id;
          w_busy_next   = 1'b0;
          w_state_next  = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign sq_in    = r_sq_in;
  assign result   = r_result;
  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign busy     = r_busy;
  assign grant_id = r_grant_id;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: two instances (settle 1 and settle 4) checked every cycle
// against a transaction-level scheduling model, plus directed scenarios.
module tb_sqrt_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]       req0, req1;
  logic [1:0][7:0]  in0, in1;
  wire  [1:0][7:0]  sq_in;
  wire  [1:0][15:0] sq_out, result;
  wire  [1:0]       ack0, ack1, busy, grant_id;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      assign sq_out[gi] = {8'hA5, sq_in[gi]};
      sqrt_arbiter #(.SETTLE_CYCLES(gi == 0 ? 1 : 4)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0[gi]), .in0(in0[gi]), .req1(req1[gi]), .in1(in1[gi]),
        .sq_in(sq_in[gi]), .sq_out(sq_out[gi]), .result(result[gi]),
        .ack0(ack0[gi]), .ack1(ack1[gi]), .busy(busy[gi]), .grant_id(grant_id[gi])
      );
    end
  endgenerate

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Model: each service occupies the server from its grant edge until grant+S.
  int          settle [2] = '{1, 4};
  int          k;
  bit          m_inflight [2];
  int          m_ch [2], m_done [2], m_ack [2];
  logic [7:0]  m_op [2], m_sqin [2];
  logic        m_grant [2], m_last [2];
  logic [15:0] m_result [2];
  bit          auto_on [2], sat [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_inflight[d] = 0; m_ack[d] = -1; m_last[d] = 1'b1; m_grant[d] = 1'b0;
      m_sqin[d] = 8'd0; m_result[d] = 16'd0;
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("d%0d ack0", d), 32'(ack0[d]), 32'(m_ack[d] == 0));
      check_val($sformatf("d%0d ack1", d), 32'(ack1[d]), 32'(m_ack[d] == 1));
      check_val($sformatf("d%0d busy", d), 32'(busy[d]), 32'(m_inflight[d]));
      check_val($sformatf("d%0d result", d), 32'(result[d]), 32'(m_result[d]));
      check_val($sformatf("d%0d sq_in", d), 32'(sq_in[d]), 32'(m_sqin[d]));
      check_val($sformatf("d%0d grant_id", d), 32'(grant_id[d]), 32'(m_grant[d]));
    end
  endtask

  // Requester behaviour, driven from the model's expected acks.
  task automatic stim(input int d);
    for (int c = 0; c < 2; c++) begin
      logic r;
      logic [7:0] v;
      r = c ? req1[d] : req0[d];
      v = c ? in1[d] : in0[d];
      if (m_ack[d] == c) begin
        if (sat[d] || $urandom_range(1) == 1) r = 1'b0;
        else v = 8'($urandom);
      end else if (!r) begin
        if (sat[d] || $urandom_range(2) == 0) begin r = 1'b1; v = 8'($urandom); end
      end else if (m_inflight[d] && m_ch[d] == c) begin
        v = 8'($urandom);
      end
      if (c == 1) begin req1[d] = r; in1[d] = v; end
      else begin req0[d] = r; in0[d] = v; end
    end
  endtask

  task automatic predict();
    for (int d = 0; d < 2; d++) begin
      int  e, nack, c;
      bit  free, e0, e1;
      if (rst) continue;
      e = k + 1; nack = -1; free = !m_inflight[d];
      if (m_inflight[d] && e == m_done[d]) begin
        nack = m_ch[d]; m_result[d] = {8'hA5, m_op[d]}; m_inflight[d] = 0;
      end
      if (free) begin
        e0 = req0[d] && m_ack[d] != 0;
        e1 = req1[d] && m_ack[d] != 1;
        if (e0 || e1) begin
          c = (e0 && e1) ? (m_last[d] ? 0 : 1) : (e1 ? 1 : 0);
          m_op[d] = c ? in1[d] : in0[d];
          m_sqin[d] = m_op[d]; m_grant[d] = c[0]; m_last[d] = c[0]; m_ch[d] = c;
          m_inflight[d] = 1; m_done[d] = e + settle[d];
        end
      end
      m_ack[d] = nack;
    end
  endtask

  task automatic step();
    for (int d = 0; d < 2; d++) if (auto_on[d]) stim(d);
    predict();
    @(negedge clk);
    k++;
    check_outputs();
  endtask

  int q0[$], q1[$], t0[$];
  logic [15:0] r0[$];
  int lat;

  initial begin
    rst = 1'b1; req0 = '0; req1 = '0; in0 = '0; in1 = '0;
    auto_on = '{0, 0}; sat = '{0, 0}; k = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_outputs();

    // Single request, settle 1.
    req0[0] = 1'b1; in0[0] = 8'h8B;
    step();
    check_val("single sq_in", 32'(sq_in[0]), 32'h8B);
    step();
    check_val("single ack0", 32'(ack0[0]), 32'd1);
    check_val("single result", 32'(result[0]), 32'hA58B);
    req0[0] = 1'b0;
    step();

    // Settle 4, operand change during WAIT must not leak through.
    req1[1] = 1'b1; in1[1] = 8'hFF;
    step();
    in1[1] = 8'h00; lat = 1;
    while (!ack1[1] && lat < 20) begin step(); lat++; end
    check_val("settle4 latency", 32'(lat), 32'd5);
    check_val("settle4 result", 32'(result[1]), 32'hA5FF);
    req1[1] = 1'b0;
    step();

    // Randomized traffic.
    auto_on = '{1, 1};
    repeat (400) step();

    // Asynchronous reset between edges, then tie on release.
    auto_on = '{0, 0};
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs();
    step();
    for (int d = 0; d < 2; d++) begin
      req0[d] = 1'b1; req1[d] = 1'b1; in0[d] = 8'h10; in1[d] = 8'h20;
    end
    rst = 1'b0;
    auto_on = '{1, 1}; sat = '{1, 1};
    repeat (32) begin
      step();
      if (ack0[0] | ack1[0]) begin q0.push_back(ack1[0] ? 1 : 0); t0.push_back(k); r0.push_back(result[0]); end
      if (ack0[1] | ack1[1]) q1.push_back(ack1[1] ? 1 : 0);
    end
    check_val("rr d0 count", 32'(q0.size() >= 6), 32'd1);
    check_val("rr d1 count", 32'(q1.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < q0.size(); i++) check_val($sformatf("rr d0 ack %0d", i), 32'(q0[i]), 32'(i % 2));
    for (int i = 0; i < 6 && i < q1.size(); i++) check_val($sformatf("rr d1 ack %0d", i), 32'(q1[i]), 32'(i % 2));
    if (q0.size() >= 2) begin
      check_val("tie first result", 32'(r0[0]), 32'hA510);
      check_val("tie second result", 32'(r0[1]), 32'hA520);
      check_val("tie no idle gap", 32'(t0[1] - t0[0]), 32'd2);
    end

    // Reset in the middle of a settle-4 computation.
    auto_on = '{0, 0}; sat = '{0, 0}; req0 = '0; req1 = '0;
    lat = 0;
    while ((m_inflight[0] || m_inflight[1]) && lat < 20) begin step(); lat++; end
    step();
    req0[1] = 1'b1; in0[1] = 8'h3C;
    step();
    step();
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs();
    step();
    rst = 1'b0;
    lat = 0;
    while (!ack0[1] && lat < 20) begin step(); lat++; end
    check_val("post-reset latency", 32'(lat), 32'd5);
    check_val("post-reset result", 32'(result[1]), 32'hA53C);
    req0[1] = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
